// File: rtl/seq_scan_ctrl.sv
// Serial-scan controller: shifts a parallel word MSB-first through an embedded Moore 10110 detector.
// Define SEQ_SCAN_CHAIN_EN to keep detector state across words; by default each word scans independently.
module seq_scan_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  din,
    output logic          busy,
    output logic          done,
    output logic          ser_bit,
    output logic          hit,
    output logic [CW-1:0] count
);

    // state | meaning
    // IDLE  | waiting for start; detector holds
    // SHIFT | presenting shreg MSB to the detector, W cycles
    // DONE  | one-cycle result pulse, count valid
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] DET_A = 3'd0;
    localparam logic [2:0] DET_B = 3'd1;
    localparam logic [2:0] DET_C = 3'd2;
    localparam logic [2:0] DET_D = 3'd3;
    localparam logic [2:0] DET_E = 3'd4;
    localparam logic [2:0] DET_F = 3'd5;

    localparam int            BW      = $clog2(W);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]    state_q,  state_d;
    logic [2:0]    det_q,    det_d;
    logic [W-1:0]  shreg_q,  shreg_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [CW-1:0] count_q,  count_d;

    function automatic logic [2:0] det_step(input logic [2:0] s, input logic b);
        logic [2:0] n;
        case (s)
            DET_A:   n = b ? DET_B : DET_A;
            DET_B:   n = b ? DET_B : DET_C;
            DET_C:   n = b ? DET_D : DET_A;
            DET_D:   n = b ? DET_E : DET_C;
            DET_E:   n = b ? DET_B : DET_F;
            DET_F:   n = b ? DET_D : DET_A;
            default: n = DET_A;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d  = state_q;
        det_d    = det_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = din;
                    bitcnt_d = '0;
                    count_d  = '0;
`ifdef SEQ_SCAN_CHAIN_EN
                    det_d    = det_q;
`else
                    det_d    = DET_A;
`endif
                end
            end
            ST_SHIFT: begin
                det_d    = det_step(det_q, shreg_q[W-1]);
                shreg_d  = {shreg_q[W-2:0], 1'b0};
                bitcnt_d = bitcnt_q + 1'b1;
                // every entry into F counts once, even when the previous scan ended in F
                if (det_d == DET_F && count_q != CNT_MAX) begin
                    count_d = count_q + 1'b1;
                end
                if (bitcnt_q == BIT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            det_q    <= DET_A;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            det_q    <= det_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            count_q  <= count_d;
        end
    end

    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);
    assign hit     = (det_q == DET_F);
    assign ser_bit = busy & shreg_q[W-1];
    assign count   = count_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: table vectors, hand sequences and random words against a pattern-window model.
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic [7:0]  din;
    logic [15:0] din2;
    logic        busy, done, ser_bit, hit;
    logic [3:0]  count;
    logic        busy2, done2, ser_bit2, hit2;
    logic [1:0]  count2;

    int          n_checks = 0;
    int          n_fail   = 0;

    // model: last five bits seen by the detector since it was last cleared
    logic [4:0]  hist;
    int          hlen;
    logic        exp_hit;

    typedef struct {
        logic [7:0] w;
        logic [3:0] c;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    seq_scan_ctrl #(.W(8), .CW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .busy(busy), .done(done), .ser_bit(ser_bit), .hit(hit), .count(count)
    );

    seq_scan_ctrl #(.W(16), .CW(2)) dut16 (
        .clk(clk), .rst(rst), .start(start2), .din(din2),
        .busy(busy2), .done(done2), .ser_bit(ser_bit2), .hit(hit2), .count(count2)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist    = '0;
        hlen    = 0;
        exp_hit = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic scan_word(input logic [7:0] w, output logic [3:0] got_cnt);
        int   exp_cnt;
        logic b;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        start = 1'b1;
        din   = w;
`ifndef SEQ_SCAN_CHAIN_EN
        model_clear();
`endif
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            din   = 8'($urandom);
            b     = w[7-i];
            chk("shift_busy", busy, 1'b1);
            chk("ser_bit", ser_bit, b);
            chk("shift_hit", hit, exp_hit);
            chk("shift_done", done, 1'b0);
            chk("shift_count", count, exp_cnt);
            hist    = {hist[3:0], b};
            hlen    = hlen + 1;
            exp_hit = (hlen >= 5) && (hist == 5'b10110);
            if (exp_hit && exp_cnt < 15) exp_cnt++;
        end
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("done_ser_bit", ser_bit, 1'b0);
        chk("done_hit", hit, exp_hit);
        chk("done_count", count, exp_cnt);
        got_cnt = count;
    endtask

    initial begin
        logic [3:0] got;
        int         seen_at;

        tbl[0] = '{8'b1011_0110, 4'd2};
        tbl[1] = '{8'h00,        4'd0};
        tbl[2] = '{8'hFF,        4'd0};
        tbl[3] = '{8'b1011_0000, 4'd1};
        tbl[4] = '{8'b0101_1010, 4'd1};
        tbl[5] = '{8'b1101_1011, 4'd1};

        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        din    = '0;
        din2   = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_ser_bit", ser_bit, 1'b0);
        chk("rst_count", count, 4'd0);
        chk("rst_busy16", busy2, 1'b0);
        chk("rst_count16", count2, 2'd0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            scan_word(tbl[i].w, got);
            chk("table_count", got, tbl[i].c);
        end

        // start held high: one done every W+2 cycles, start ignored while busy
        do_reset();
        @(negedge clk);
        start = 1'b1;
        din   = 8'b1011_0110;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            chk("hold_done", done, (k % 10) == 9);
            chk("hold_busy", busy, (k % 10) >= 1 && (k % 10) <= 8);
            if ((k % 10) == 9) chk("hold_count", count, 4'd2);
        end
        start = 1'b0;

        // chaining across words
        do_reset();
        scan_word(8'b0000_0101, got);
        chk("chain_first", got, 4'd0);
        scan_word(8'b1000_0000, got);
`ifdef SEQ_SCAN_CHAIN_EN
        chk("chain_second", got, 4'd1);
`else
        chk("chain_second", got, 4'd0);
`endif

        // reset during the 4th shift cycle aborts the scan
        do_reset();
        @(negedge clk);
        start = 1'b1;
        din   = 8'b1011_0110;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        chk("abort_busy", busy, 1'b0);
        chk("abort_count", count, 4'd0);
        chk("abort_hit", hit, 1'b0);
        chk("abort_done", done, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        scan_word(8'b1011_0110, got);
        chk("after_abort_count", got, 4'd2);

        // random words back to back, checked cycle by cycle against the model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            scan_word(8'($urandom), got);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // W=16, CW=2: four matches saturate at 3
        do_reset();
        @(negedge clk);
        start2 = 1'b1;
        din2   = 16'b1011_0110_1101_1010;
        @(negedge clk);
        start2  = 1'b0;
        seen_at = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done2) begin
                seen_at = k;
                break;
            end
            @(negedge clk);
        end
        chk("w16_latency", seen_at, 17);
        chk("w16_count", count2, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
